// File: rtl/or_and_gate.sv
// Four-input product-of-sums gate q = (a|b)&(c|d),
// with a registered copy q_r for timing-closed consumers.
module or_and_gate (
   input  logic clk,
   input  logic rst_n,
   input  logic a,
   input  logic b,
   input  logic c,
   input  logic d,
   output logic q,
   output logic q_r
);

   // q ignores clk and rst_n; only q_r is reset
   assign q = (a | b) & (c | d);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q_r <= 1'b0;
      end else begin
         q_r <= q;
      end
   end

endmodule

// File: tb/tb_or_and_gate.sv
// Bench for or_and_gate: randomized and directed vectors on both clk edges,
// expected values queued by the driver and checked by a separate monitor.
module tb_or_and_gate;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic a = 1'b0;
   logic b = 1'b0;
   logic c = 1'b0;
   logic d = 1'b0;
   logic q;
   logic q_r;

   or_and_gate dut (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (a),
      .b     (b),
      .c     (c),
      .d     (d),
      .q     (q),
      .q_r   (q_r)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] v;
      logic       r;
   } step_t;

   typedef struct {
      logic [3:0] v;
      logic       q;
      logic       qr;
   } item_t;

   step_t steps[$];
   item_t sb[$];

   // q for index {a,b,c,d} is bit {a,b,c,d} of this truth-table mask
   logic [15:0] mask = 16'hEEE0;

   int passed = 0;
   int total = 0;

   function automatic logic ref_q(input logic [3:0] v);
      return mask[v];
   endfunction

   task automatic add(input logic [3:0] v, input logic r);
      step_t s;
      s.v = v;
      s.r = r;
      steps.push_back(s);
   endtask

   task automatic check(input string name, input logic [3:0] v,
                        input logic got, input logic exp);
      total++;
      if (got === exp) begin
         passed++;
      end else begin
         $display("FAIL %s vec=%b got=%b exp=%b t=%0t",
                  name, v, got, exp, $time);
      end
   endtask

   task automatic drive_all();
      logic [3:0] cur_v;
      logic       cur_r;
      logic       exp_qr;
      item_t      it;
      cur_v = 4'b0000;
      cur_r = 1'b0;
      exp_qr = 1'b0;
      foreach (steps[i]) begin
         @(posedge clk or negedge clk);
         if (clk) begin
            exp_qr = cur_r ? ref_q(cur_v) : 1'b0;
         end
         #1;
         {a, b, c, d} = steps[i].v;
         rst_n = steps[i].r;
         cur_v = steps[i].v;
         cur_r = steps[i].r;
         it.v = steps[i].v;
         it.q = ref_q(steps[i].v);
         it.qr = exp_qr;
         sb.push_back(it);
      end
   endtask

   task automatic monitor_all(input int n);
      item_t it;
      for (int i = 0; i < n; i++) begin
         @(posedge clk or negedge clk);
         #3;
         if (sb.size() == 0) begin
            total++;
            $display("FAIL sb_empty step=%0d got=0 exp=1 t=%0t", i, $time);
         end else begin
            it = sb.pop_front();
            check("q", it.v, q, it.q);
            check("q_r", it.v, q_r, it.qr);
         end
      end
   endtask

   initial begin
      logic [3:0] v;
      // reset with random inputs
      for (int i = 0; i < 2; i++) add(4'($urandom_range(0, 15)), 1'b0);
      // exhaustive sweep
      for (int i = 0; i < 16; i++) add(4'(i), 1'b1);
      // one OR-pair only, then both pairs
      add(4'b1000, 1'b1);
      add(4'b0010, 1'b1);
      add(4'b0101, 1'b1);
      // reset held across two rising edges with all inputs high
      for (int i = 0; i < 4; i++) add(4'b1111, 1'b0);
      for (int i = 0; i < 3; i++) add(4'b1111, 1'b1);
      // a=c=1 dominates; a=b=0 forces low
      for (int i = 0; i < 4; i++) begin
         v = 4'($urandom_range(0, 15));
         add({1'b1, v[2], 1'b1, v[0]}, 1'b1);
      end
      for (int i = 0; i < 4; i++) begin
         v = 4'($urandom_range(0, 15));
         add({2'b00, v[1:0]}, 1'b1);
      end
      // random vectors with occasional reset pulses
      for (int i = 0; i < 100; i++) begin
         add(4'($urandom_range(0, 15)),
             ($urandom_range(0, 15) != 0));
      end
      fork
         drive_all();
         monitor_all(steps.size());
      join
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got=running exp=done t=%0t", $time);
      $fatal(1, "timeout");
   end

endmodule
